// File: rtl/vga_sync_decoder.sv
// rtl/vga_sync_decoder.sv - VGA receive-side timing recovery: raster position, data-enable, lock and error count.
// Optional build macro VGA_DECODER_CRC_EN adds a per-frame CRC-16/CCITT of the visible pixels.
module vga_sync_decoder #(
    parameter int   H_VISIBLE   = 640,
    parameter int   H_FP        = 16,
    parameter int   H_SYNC      = 96,
    parameter int   H_BP        = 48,
    parameter int   V_VISIBLE   = 480,
    parameter int   V_FP        = 10,
    parameter int   V_SYNC      = 2,
    parameter int   V_BP        = 33,
    parameter logic SYNC_ACTIVE = 1'b0,
    parameter int   LOCK_FRAMES = 2,
    parameter int   H_TIMEOUT   = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        px_en,
    input  logic        hsync,
    input  logic        vsync,
    input  logic [29:0] rgb_in,
    output logic [10:0] x,
    output logic [10:0] y,
    output logic        de,
    output logic [29:0] px_out,
    output logic        locked,
    output logic        frame_start,
    output logic [7:0]  err_count
`ifdef VGA_DECODER_CRC_EN
    ,
    output logic [15:0] frame_crc
`endif
);
    localparam logic [10:0] H_LAST   = 11'(H_VISIBLE + H_FP + H_SYNC + H_BP - 1);
    localparam logic [10:0] V_LAST   = 11'(V_VISIBLE + V_FP + V_SYNC + V_BP - 1);
    localparam logic [10:0] H_LOAD   = 11'(H_VISIBLE + H_FP);
    localparam logic [10:0] V_LOAD   = 11'(V_VISIBLE + V_FP);
    localparam logic [10:0] H_VIS    = 11'(H_VISIBLE);
    localparam logic [10:0] V_VIS    = 11'(V_VISIBLE);
    localparam logic [10:0] TO_LAST  = 11'(H_TIMEOUT - 1);
    localparam logic [3:0]  LOCK_CNT = 4'(LOCK_FRAMES);

    typedef enum logic [1:0] {SEARCH, TRACK, LOCKED} state_t;

    state_t      state_q, state_d;
    logic        hs_q, hs_prev_q, vs_q, vs_prev_q;
    logic [29:0] rgb_q;
    logic [10:0] hcnt_q, hcnt_d, vcnt_q, vcnt_d, to_q, to_d;
    logic [3:0]  clean_q, clean_d;
    logic [7:0]  err_q, err_d;
    logic [10:0] x_q, x_d, y_q, y_d;
    logic        de_q, de_d, locked_q, locked_d, fs_q, fs_d;
    logic [29:0] px_q, px_d;
    logic        h_edge, v_edge, h_wrap, tracking, h_err, v_err;
    logic [10:0] h_next, v_next;

    // Counters label the sample currently held in the capture registers.
    always_comb begin
        h_edge   = (hs_q == SYNC_ACTIVE) && (hs_prev_q != SYNC_ACTIVE);
        v_edge   = (vs_q == SYNC_ACTIVE) && (vs_prev_q != SYNC_ACTIVE);
        h_wrap   = (hcnt_q == H_LAST);
        h_next   = h_wrap ? 11'd0 : hcnt_q + 11'd1;
        if (!h_wrap)
            v_next = vcnt_q;
        else if (vcnt_q == V_LAST)
            v_next = 11'd0;
        else
            v_next = vcnt_q + 11'd1;
        tracking = (state_q != SEARCH);
        h_err    = tracking && (h_edge ? (h_next != H_LOAD) : (to_q == TO_LAST));
        v_err    = tracking && v_edge && (v_next != V_LOAD);

        state_d  = state_q;
        hcnt_d   = h_next;
        vcnt_d   = v_next;
        clean_d  = clean_q;
        err_d    = err_q;
        to_d     = (h_edge || !tracking) ? 11'd0 : to_q + 11'd1;

        // An error beats a simultaneous sync edge: no counter reload.
        if (h_err || v_err) begin
            state_d = SEARCH;
            to_d    = 11'd0;
            if (err_q != 8'hFF)
                err_d = err_q + 8'd1;
        end else begin
            if (h_edge)
                hcnt_d = H_LOAD;
            if (v_edge) begin
                vcnt_d = V_LOAD;
                case (state_q)
                    SEARCH: begin
                        state_d = TRACK;
                        clean_d = 4'd0;
                    end
                    TRACK: begin
                        clean_d = clean_q + 4'd1;
                        if (clean_q + 4'd1 >= LOCK_CNT)
                            state_d = LOCKED;
                    end
                    default: ;
                endcase
            end
        end

        locked_d = (state_d == LOCKED);
        de_d     = locked_d && (hcnt_d < H_VIS) && (vcnt_d < V_VIS);
        x_d      = (state_d == SEARCH) ? 11'd0 : hcnt_d;
        y_d      = (state_d == SEARCH) ? 11'd0 : vcnt_d;
        px_d     = de_d ? rgb_q : 30'd0;
        fs_d     = locked_d && (hcnt_d == 11'd0) && (vcnt_d == 11'd0);
    end

`ifdef VGA_DECODER_CRC_EN
    localparam logic [15:0] CRC_SEED = 16'hFFFF;
    logic [15:0] acc_q, crc_q;

    function automatic logic [15:0] crc30(input logic [15:0] c, input logic [29:0] d);
        logic [15:0] r;
        r = c;
        for (int i = 29; i >= 0; i--)
            r = {r[14:0], 1'b0} ^ ((r[15] ^ d[i]) ? 16'h1021 : 16'h0000);
        return r;
    endfunction

    assign frame_crc = crc_q;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= SEARCH;
            hs_q      <= 1'b0;
            hs_prev_q <= 1'b0;
            vs_q      <= 1'b0;
            vs_prev_q <= 1'b0;
            rgb_q     <= 30'd0;
            hcnt_q    <= 11'd0;
            vcnt_q    <= 11'd0;
            to_q      <= 11'd0;
            clean_q   <= 4'd0;
            err_q     <= 8'd0;
            x_q       <= 11'd0;
            y_q       <= 11'd0;
            de_q      <= 1'b0;
            px_q      <= 30'd0;
            locked_q  <= 1'b0;
            fs_q      <= 1'b0;
`ifdef VGA_DECODER_CRC_EN
            acc_q     <= CRC_SEED;
            crc_q     <= 16'd0;
`endif
        end else begin
            fs_q <= 1'b0;
            if (px_en) begin
                hs_q      <= hsync;
                hs_prev_q <= hs_q;
                vs_q      <= vsync;
                vs_prev_q <= vs_q;
                rgb_q     <= rgb_in;
                state_q   <= state_d;
                hcnt_q    <= hcnt_d;
                vcnt_q    <= vcnt_d;
                to_q      <= to_d;
                clean_q   <= clean_d;
                err_q     <= err_d;
                x_q       <= x_d;
                y_q       <= y_d;
                de_q      <= de_d;
                px_q      <= px_d;
                locked_q  <= locked_d;
                fs_q      <= fs_d;
`ifdef VGA_DECODER_CRC_EN
                // The frame's first pixel coincides with frame_start, so fold it into a fresh seed.
                if (state_d == SEARCH) begin
                    acc_q <= CRC_SEED;
                end else if (fs_d) begin
                    crc_q <= acc_q;
                    acc_q <= crc30(CRC_SEED, px_d);
                end else if (de_d) begin
                    acc_q <= crc30(acc_q, px_d);
                end
`endif
            end
        end
    end

    assign x           = x_q;
    assign y           = y_q;
    assign de          = de_q;
    assign px_out      = px_q;
    assign locked      = locked_q;
    assign frame_start = fs_q;
    assign err_count   = err_q;
endmodule

// File: tb/tb_vga_sync_decoder.sv
// tb/tb_vga_sync_decoder.sv - directed bench for vga_sync_decoder using a reduced 16x9 raster.
module tb_vga_sync_decoder;
    localparam int HV = 8, HFP = 2, HS = 3, HBP = 3, HT = HV + HFP + HS + HBP;
    localparam int VV = 4, VFP = 1, VS = 2, VBP = 2, VT = VV + VFP + VS + VBP;

    logic        clk = 1'b0, rst = 1'b0, px_en = 1'b0, hsync = 1'b1, vsync = 1'b1;
    logic [29:0] rgb_in = 30'd0;
    logic [10:0] x, y;
    logic        de, locked, frame_start;
    logic [29:0] px_out;
    logic [7:0]  err_count;
`ifdef VGA_DECODER_CRC_EN
    logic [15:0] frame_crc;
    logic [15:0] crc_model;
`endif

    int checks = 0, errors = 0;
    int gh = 0, gv = 0, ph = 0, pv = 0, oh = 0, ov = 0;
    int bad, dec, fsc;
    bit kill = 1'b0, vis;
    logic [10:0] sx, sy;

    vga_sync_decoder #(
        .H_VISIBLE(HV), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
        .V_VISIBLE(VV), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
        .SYNC_ACTIVE(1'b0), .LOCK_FRAMES(2), .H_TIMEOUT(1024)
    ) dut (
        .clk(clk), .rst(rst), .px_en(px_en), .hsync(hsync), .vsync(vsync), .rgb_in(rgb_in),
        .x(x), .y(y), .de(de), .px_out(px_out), .locked(locked),
        .frame_start(frame_start), .err_count(err_count)
`ifdef VGA_DECODER_CRC_EN
        , .frame_crc(frame_crc)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [29:0] rgbf(input int h, input int v);
        return {v[9:0], h[9:0], 10'h2A5};
    endfunction

`ifdef VGA_DECODER_CRC_EN
    function automatic logic [15:0] crc30(input logic [15:0] c, input logic [29:0] d);
        logic [15:0] r;
        r = c;
        for (int i = 29; i >= 0; i--)
            r = {r[14:0], 1'b0} ^ ((r[15] ^ d[i]) ? 16'h1021 : 16'h0000);
        return r;
    endfunction
`endif

    task automatic sample(input logic hs, input logic vs, input logic [29:0] d);
        hsync  = hs;
        vsync  = vs;
        rgb_in = d;
        px_en  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        px_en  = 1'b0;
    endtask

    task automatic tick();
        logic hs, vs;
        hs = (!kill && gh >= HV + HFP && gh < HV + HFP + HS) ? 1'b0 : 1'b1;
        vs = (gv >= VV + VFP && gv < VV + VFP + VS) ? 1'b0 : 1'b1;
        sample(hs, vs, rgbf(gh, gv));
        oh = ph; ov = pv; ph = gh; pv = gv;
        gh++;
        if (gh == HT) begin
            gh = 0;
            gv = (gv + 1) % VT;
        end
    endtask

    task automatic run_ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic run_to(input int v, input int h);
        for (int i = 0; i < 400 && !(gv == v && gh == h); i++) tick();
        chk("run_to_reached", (gv == v && gh == h), 1);
    endtask

    task automatic err_period();
        sample(1'b1, 1'b1, 30'd0);
        sample(1'b1, 1'b0, 30'd0);
        sample(1'b0, 1'b1, 30'd0);
        sample(1'b1, 1'b1, 30'd0);
        sample(1'b0, 1'b1, 30'd0);
        sample(1'b1, 1'b1, 30'd0);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_x", x, 0);
        chk("rst_y", y, 0);
        chk("rst_de", de, 0);
        chk("rst_locked", locked, 0);
        chk("rst_err", err_count, 0);
        rst = 1'b1;

        // Acquisition: first vsync edge enters TRACK, two clean frames then lock.
        run_to(5, 2);
        chk("track_locked", locked, 0);
        chk("track_y", y, 5);
        chk("track_x", x, 0);
        run_ticks(287);
        chk("prelock_locked", locked, 0);
        run_ticks(1);
        chk("lock_locked", locked, 1);
        chk("lock_y", y, 5);
        chk("lock_err", err_count, 0);

        run_to(0, 1);
        chk("pre_fs", frame_start, 0);
        tick();
        chk("fs_pulse", frame_start, 1);
        chk("fs_x", x, 0);
        chk("fs_y", y, 0);
        chk("fs_px", px_out, rgbf(0, 0));
`ifdef VGA_DECODER_CRC_EN
        chk("crc_first", frame_crc, 16'hFFFF);
`endif
        sx = x; sy = y;
        @(posedge clk);
        @(negedge clk);
        chk("stall_fs", frame_start, 0);
        chk("stall_x", x, sx);
        chk("stall_de", de, 1);
        chk("stall_px", px_out, rgbf(0, 0));

        bad = 0; dec = 0; fsc = 0;
        repeat (HT * VT) begin
            tick();
            vis = (oh < HV) && (ov < VV);
            if (x !== oh[10:0] || y !== ov[10:0] || de !== vis ||
                px_out !== (vis ? rgbf(oh, ov) : 30'd0) || frame_start !== (oh == 0 && ov == 0))
                bad++;
            dec += int'(de);
            fsc += int'(frame_start);
        end
        chk("frame_pixels_bad", bad, 0);
        chk("frame_de_count", dec, HV * VV);
        chk("frame_start_count", fsc, 1);
        chk("frame_err", err_count, 0);
`ifdef VGA_DECODER_CRC_EN
        crc_model = 16'hFFFF;
        for (int v = 0; v < VV; v++)
            for (int h = 0; h < HV; h++)
                crc_model = crc30(crc_model, rgbf(h, v));
        chk("crc_frame", frame_crc, crc_model);
        run_ticks(HT * VT);
        chk("crc_repeat", frame_crc, crc_model);
`endif

        // Short line: drop one pixel from line 1 while locked.
        run_to(1, 3);
        gh = 4;
        run_to(1, 11);
        chk("short_still_locked", locked, 1);
        run_to(1, 12);
        chk("short_locked", locked, 0);
        chk("short_err", err_count, 1);
        chk("short_de", de, 0);
        chk("short_x", x, 0);
        run_to(5, 2);
        chk("relock_track", locked, 0);
        chk("relock_track_y", y, 5);
        run_ticks(287);
        chk("relock_pre", locked, 0);
        run_ticks(1);
        chk("relock_locked", locked, 1);
        chk("relock_err", err_count, 1);

        // Missing hsync for 1100 samples trips the timeout once.
        kill = 1'b1;
        run_ticks(1100);
        kill = 1'b0;
        chk("timeout_locked", locked, 0);
        chk("timeout_err", err_count, 2);
        chk("timeout_de", de, 0);
        run_ticks(500);
        chk("timeout_relock", locked, 1);

        // Asynchronous reset mid-line.
        run_to(1, 7);
        chk("mid_x", x, 5);
        chk("mid_locked", locked, 1);
        #1 rst = 1'b0;
        #1;
        chk("arst_x", x, 0);
        chk("arst_y", y, 0);
        chk("arst_de", de, 0);
        chk("arst_px", px_out, 0);
        chk("arst_locked", locked, 0);
        chk("arst_err", err_count, 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        run_ticks(250);
        chk("post_rst_unlocked", locked, 0);
        run_ticks(150);
        chk("post_rst_relock", locked, 1);

        // Saturation: each six-sample period forces exactly one error.
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        repeat (254) err_period();
        chk("sat_254", err_count, 254);
        repeat (46) err_period();
        chk("sat_255", err_count, 255);
        chk("sat_locked", locked, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
